fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_skid_buf.sv | 52 +++++
 rtl/fifo_rd_stream.sv | 69 ++++++
 tb/tb_fifo_rd_stream.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read path: default beat width, beat type and counter sizing.
// Pure declarations; no logic, latency or flow control of its own.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int PKT_LEN_MAX = 256;

  typedef logic [DEF_DATA_W-1:0] data_t;

  // A 1-beat packet still needs a 1-bit counter to keep ports and compares legal.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order beat buffer; a pushed beat becomes the head on the next edge when empty.
// No backpressure of its own: the caller never pushes while full or pops while empty.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int W = DEF_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   occ,
  output logic [W-1:0] head
);

  logic [W-1:0] tail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      occ <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= push_data;
          else             tail <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; the new beat lands behind whatever survives the pop.
          if (occ == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Turns a read-strobe FIFO into a valid/ready beat stream with packet-last marking.
// Latency 2 cycles rden->o_valid; stalls on i_ready low with at most 2 beats buffered plus in flight.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PKT_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rden,
  input  logic [DATA_W-1:0] fifo_rddata,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last
);

  localparam int CNT_W = cnt_width(PKT_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

  logic [1:0]       occ;
  logic             inflight;
  logic             rst_done;
  logic             pop;
  logic             push;
  logic [2:0]       committed;
  logic [CNT_W-1:0] beat_cnt;

  assign pop       = o_valid & i_ready;
  assign push      = inflight & ~i_flush;
  assign committed = {1'b0, occ} + {2'b00, inflight};

  // rst_done holds off the first read until one edge has passed since reset release.
  assign fifo_rden = rst_done & ~fifo_empty & ~i_flush
                   & (committed < (3'd2 + {2'b00, pop}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_done <= 1'b0;
      inflight <= 1'b0;
      beat_cnt <= '0;
    end else begin
      rst_done <= 1'b1;
      inflight <= fifo_rden;
      if (i_flush)
        beat_cnt <= '0;
      else if (pop)
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
    end
  end

  fifo_skid_buf #(.W(DATA_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (i_flush),
    .push      (push),
    .push_data (fifo_rddata),
    .pop       (pop),
    .occ       (occ),
    .head      (o_data)
  );

  assign o_valid = (occ != 2'd0);
  assign o_last  = o_valid & (beat_cnt == LAST_BEAT);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a 4-beat-packet instance and a 1-beat-packet instance.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int PKT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- instance with 4-beat packets ----------------
  logic  fifo_empty, fifo_rden, o_valid, o_last;
  logic  i_flush = 1'b0;
  logic  i_ready = 1'b1;
  data_t fifo_rddata = '0;
  data_t o_data;
  data_t mem [0:255];
  int    wr_cnt = 0;
  int    rd_cnt = 0;

  assign fifo_empty = (rd_cnt == wr_cnt);
  always @(posedge clk) if (fifo_rden) begin
    fifo_rddata <= mem[rd_cnt % 256];
    rd_cnt      <= rd_cnt + 1;
  end

  fifo_rd_stream #(.DATA_W(DEF_DATA_W), .PKT_LEN(PKT)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rden(fifo_rden),
    .fifo_rddata(fifo_rddata), .i_flush(i_flush), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data), .o_last(o_last)
  );

  logic [8:0] exp_q[$];
  int exp_idx = 0;

  task automatic push_fifo(input data_t d);
    mem[wr_cnt % 256] = d;
    wr_cnt++;
  endtask

  task automatic load(input data_t d);
    push_fifo(d);
    exp_q.push_back({(exp_idx == PKT - 1), d});
    exp_idx = (exp_idx + 1) % PKT;
  endtask

  logic       prev_stall = 1'b0;
  data_t      prev_data;
  logic       prev_last;
  logic [8:0] e_mon;
  int held = 0, pops = 0, rden_cnt = 0, vld_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      held = 0;
      prev_stall = 1'b0;
    end else begin
      if (fifo_rden) rden_cnt++;
      if (o_valid) vld_cnt++;
      chk("rden_while_empty", int'(fifo_rden & fifo_empty), 0);
      if (o_valid && prev_stall) begin
        chk("hold_data", int'(o_data), int'(prev_data));
        chk("hold_last", int'(o_last), int'(prev_last));
      end
      if (o_valid && i_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%0h required=none", o_data);
        end else begin
          e_mon = exp_q.pop_front();
          chk("beat_data", int'(o_data), int'(e_mon[7:0]));
          chk("beat_last", int'(o_last), int'(e_mon[8]));
        end
      end
      held = held + int'(fifo_rden) - int'(o_valid && i_ready);
      if (i_flush) held = 0;
      chk("occ_plus_inflight_le2", int'(held <= 2), 1);
      prev_stall = o_valid & ~i_ready & ~i_flush;
      prev_data  = o_data;
      prev_last  = o_last;
    end
  end

  // ---------------- instance with 1-beat packets ----------------
  logic  fifo_empty1, fifo_rden1, o_valid1, o_last1;
  logic  i_flush1 = 1'b0;
  logic  i_ready1 = 1'b1;
  data_t fifo_rddata1 = '0;
  data_t o_data1;
  data_t mem1 [0:255];
  int    wr_cnt1 = 0;
  int    rd_cnt1 = 0;
  data_t exp1_q[$];
  data_t e_mon1;

  assign fifo_empty1 = (rd_cnt1 == wr_cnt1);
  always @(posedge clk) if (fifo_rden1) begin
    fifo_rddata1 <= mem1[rd_cnt1 % 256];
    rd_cnt1      <= rd_cnt1 + 1;
  end

  fifo_rd_stream #(.DATA_W(DEF_DATA_W), .PKT_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty1), .fifo_rden(fifo_rden1),
    .fifo_rddata(fifo_rddata1), .i_flush(i_flush1), .o_valid(o_valid1),
    .i_ready(i_ready1), .o_data(o_data1), .o_last(o_last1)
  );

  always @(negedge clk) begin
    if (!rst) begin
      chk("last_eq_valid_pkt1", int'(o_last1), int'(o_valid1));
      if (o_valid1 && i_ready1) begin
        if (exp1_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat_pkt1 actual=%0h required=none", o_data1);
        end else begin
          e_mon1 = exp1_q.pop_front();
          chk("beat_data_pkt1", int'(o_data1), int'(e_mon1));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int r, v, lastv, nv, n, r0, v0, p0;

    // Preloaded packet; FIFO non-empty throughout reset.
    load(8'h11); load(8'h22); load(8'h33); load(8'h44);
    #1;
    chk("rst_o_valid", int'(o_valid), 0);
    chk("rst_o_last",  int'(o_last), 0);
    chk("rst_o_data",  int'(o_data), 0);
    chk("rst_rden",    int'(fifo_rden), 0);
    chk("rst_o_valid_pkt1", int'(o_valid1), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 chk("rden_before_first_edge", int'(fifo_rden), 0);

    r = -1; v = -1; lastv = -1; nv = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (fifo_rden && r < 0) r = k;
      if (o_valid) begin
        if (v < 0) v = k;
        lastv = k;
        nv++;
      end
    end
    chk("first_beat_latency", v - r, 2);
    chk("stream_beats", nv, 4);
    chk("stream_back_to_back", lastv - v, 3);
    chk("drain_preload", exp_q.size(), 0);

    // Eight beats with a four-cycle stall.
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) load(data_t'(8'h51 + i));
    for (int k = 0; k < 25; k++) begin
      i_ready = !(k >= 3 && k <= 6);
      @(posedge clk); #1;
    end
    i_ready = 1'b1;
    chk("drain_stall", exp_q.size(), 0);

    // Single beat then empty.
    r0 = rden_cnt; v0 = vld_cnt;
    load(8'h99);
    repeat (8) @(posedge clk);
    #1;
    chk("single_rden_count", rden_cnt - r0, 1);
    chk("single_valid_pulse", vld_cnt - v0, 1);
    chk("drain_single", exp_q.size(), 0);

    // Flush with one beat buffered and one in flight.
    i_ready = 1'b0;
    push_fifo(8'hA1);
    n = 0;
    while (!o_valid && n < 10) begin @(negedge clk); n++; end
    chk("flush_setup_valid", int'(o_valid), 1);
    #1 push_fifo(8'hA2);
    @(posedge clk); #1;
    i_flush = 1'b1;
    #1;
    chk("flush_cycle_valid", int'(o_valid), 1);
    chk("flush_cycle_rden", int'(fifo_rden), 0);
    @(posedge clk); #1;
    i_flush = 1'b0;
    exp_idx = 0;
    chk("after_flush_valid", int'(o_valid), 0);
    v0 = vld_cnt;
    repeat (4) @(posedge clk);
    #1 chk("inflight_discarded", vld_cnt - v0, 0);
    i_ready = 1'b1;
    load(8'hB1); load(8'hB2); load(8'hB3); load(8'hB4);
    repeat (10) @(posedge clk);
    #1 chk("drain_after_flush", exp_q.size(), 0);

    // Reset mid-packet with a beat in flight.
    p0 = pops;
    load(8'hC1); load(8'hC2); load(8'hC3); load(8'hC4);
    n = 0;
    while (pops < p0 + 2 && n < 20) begin @(posedge clk); n++; end
    #1 rst = 1'b1;
    #1;
    chk("midrst_o_valid", int'(o_valid), 0);
    chk("midrst_o_last",  int'(o_last), 0);
    chk("midrst_o_data",  int'(o_data), 0);
    chk("midrst_rden",    int'(fifo_rden), 0);
    exp_q.delete();
    exp_idx = 0;
    wr_cnt = rd_cnt;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    load(8'hD1); load(8'hD2); load(8'hD3); load(8'hD4);
    repeat (12) @(posedge clk);
    #1 chk("drain_after_reset", exp_q.size(), 0);

    // One-beat packets under random backpressure.
    for (int i = 0; i < 10; i++) begin
      mem1[wr_cnt1 % 256] = data_t'(8'h60 + i);
      wr_cnt1++;
      exp1_q.push_back(data_t'(8'h60 + i));
    end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      i_ready1 = 1'($urandom_range(0, 1));
    end
    i_ready1 = 1'b1;
    repeat (8) @(posedge clk);
    #1 chk("drain_pkt1", exp1_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
